// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// instr_encoder : encodes R/I/S-type requests into 9-bit words, writes imem.
// Optional macro INSTR_ENC_COUNT_EN enables the enc_count write counter.
// Revision 1.0
// ============================================================================
module instr_encoder #(
  parameter int ADDR_W     = 8,
  parameter int IMEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [2:0]        in_op,
  input  logic [3:0]        in_rs,
  input  logic [3:0]        in_rt,
  input  logic [2:0]        in_imm,
  input  logic [6:0]        in_sidx,
  input  logic              load_addr,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [8:0]        wr_data,
  output logic              full,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [15:0]       enc_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    WRITE  = 2'd2,
    FULLST = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [1:0]        r_kind;
  logic [2:0]        r_op;
  logic [3:0]        r_rs;
  logic [3:0]        r_rt;
  logic [2:0]        r_imm;
  logic [6:0]        r_sidx;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [8:0]        r_wr_data;
  logic              r_full;
  logic              r_err;
  logic [1:0]        r_err_code;

  logic              w_reload;
  logic              w_accept;
  logic              w_legal;
  logic [8:0]        w_word;
  logic [1:0]        w_code;

  assign w_reload = load_addr && (r_state == IDLE || r_state == FULLST);
  assign w_accept = (r_state == IDLE) && !load_addr && in_valid;

  // Gated by rst_n so the handshake reads low while reset is held.
  assign in_ready = rst_n && (r_state == IDLE) && !load_addr;
  assign wr_en    = (r_state == WRITE);
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign full     = r_full;
  assign err      = r_err;
  assign err_code = r_err_code;

  always_comb begin
    w_legal = 1'b0;
    w_word  = 9'd0;
    w_code  = 2'b00;
    case (r_kind)
      2'b00: begin
        w_legal = (r_rs[3:2] == 2'b00) && (r_rt[3:2] == 2'b00);
        w_word  = {1'b0, r_op, r_rs[1:0], r_rt[1:0], 1'b0};
      end
      2'b01: begin
        // lov carries a 3-bit register field in place of the immediate.
        if (r_op == 3'b010) begin
          w_legal = !r_rs[3];
          w_word  = {1'b1, 3'b010, r_rs[2:0], 2'b00};
        end else begin
          w_legal = (r_rs[3:2] == 2'b00);
          w_word  = {1'b1, r_op, r_rs[1:0], r_imm};
        end
      end
      2'b10: begin
        w_legal = 1'b1;
        w_word  = {1'b0, r_sidx, 1'b1};
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
    if (!w_legal) begin
      w_code = (r_kind == 2'b11) ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (!load_addr && in_valid) w_next = CHECK;
      CHECK:   w_next = w_legal ? WRITE : IDLE;
      WRITE:   w_next = (r_wr_addr == LAST_ADDR) ? FULLST : IDLE;
      FULLST:  if (load_addr) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kind     <= 2'b00;
      r_op       <= 3'd0;
      r_rs       <= 4'd0;
      r_rt       <= 4'd0;
      r_imm      <= 3'd0;
      r_sidx     <= 7'd0;
      r_wr_addr  <= '0;
      r_wr_data  <= 9'd0;
      r_full     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
    end else begin
      if (w_reload) begin
        r_wr_addr  <= start_addr;
        r_full     <= 1'b0;
        r_err      <= 1'b0;
        r_err_code <= 2'b00;
      end
      if (w_accept) begin
        r_kind <= in_kind;
        r_op   <= in_op;
        r_rs   <= in_rs;
        r_rt   <= in_rt;
        r_imm  <= in_imm;
        r_sidx <= in_sidx;
      end
      if (r_state == CHECK) begin
        if (w_legal) begin
          r_wr_data <= w_word;
        end else begin
          r_err      <= 1'b1;
          r_err_code <= w_code;
        end
      end
      // The last address is held rather than wrapped so nothing is overwritten.
      if (r_state == WRITE) begin
        if (r_wr_addr == LAST_ADDR) begin
          r_full <= 1'b1;
        end else begin
          r_wr_addr <= r_wr_addr + ADDR_W'(1);
        end
      end
    end
  end

`ifdef INSTR_ENC_COUNT_EN
  logic [15:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 16'd0;
    end else if (w_reload) begin
      r_count <= 16'd0;
    end else if (r_state == WRITE && r_count != 16'hFFFF) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign enc_count = r_count;
`else
  assign enc_count = 16'd0;
`endif

endmodule
`default_nettype wire

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Encodes register-level instruction requests into the 9-bit machine words that the register-lookup decoder consumes. Three formats are supported: R-type, I-type and S-type (special-index).
- Writes each encoded word into instruction memory at an auto-incrementing address.
- Sits between the program loader/test harness and the instruction memory.
- Rejects requests the 9-bit format cannot represent and flags them with a sticky error.

Parameters:
- ADDR_W, 8, width of the instruction-memory address.
- IMEM_DEPTH, 256, number of writable words; must be no greater than 2**ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request present
- in_ready  out  1  encoder can accept a request this cycle
- in_kind  in  2  format: 00 R-type, 01 I-type, 10 S-type, 11 illegal
- in_op  in  3  opcode, placed in word bits [7:5] (R and I formats)
- in_rs  in  4  source/destination register index
- in_rt  in  4  second register index (R format)
- in_imm  in  3  immediate (I format)
- in_sidx  in  7  special-instruction index (S format)
- load_addr  in  1  reload the write address; clears full and err
- start_addr  in  ADDR_W  address loaded by load_addr
- wr_en  out  1  instruction-memory write strobe
- wr_addr  out  ADDR_W  write address
- wr_data  out  9  encoded instruction word
- full  out  1  last address has been written
- err  out  1  sticky error flag
- err_code  out  2  cause of the most recent error: 01 register out of range, 10 illegal kind
- enc_count  out  16  count of words written (see Optional Feature)

Behaviour:
- Reset values: in_ready=0, wr_en=0, wr_addr=0, wr_data=0, full=0, err=0, err_code=0, enc_count=0. The state machine goes to IDLE. Asserting reset mid-operation drops any pending request with no write.
- States are IDLE, CHECK, WRITE and FULLST.
- IDLE: in_ready=1.
  - load_addr has priority over a request. When load_addr=1: wr_addr<=start_addr, full<=0, err<=0, err_code<=0, and in_ready=0 that cycle.
  - Otherwise, when in_valid&&in_ready: capture all in_* fields and go to CHECK.
- CHECK (1 cycle): in_ready=0. Validate and encode the captured fields.
  - R-type: requires rs<4 and rt<4. word = {1'b0, op, rs[1:0], rt[1:0], 1'b0}.
  - I-type with op=010 (lov): requires rs<8. word = {1'b1, 3'b010, rs[2:0], 2'b00}.
  - I-type, any other op: requires rs<4. word = {1'b1, op, rs[1:0], imm}.
  - S-type: always legal. word = {1'b0, sidx, 1'b1}.
  - kind=11: err_code=10.
  - Out-of-range register: err_code=01.
  - On any error: err<=1, no write, go to IDLE.
  - When legal: latch wr_data and go to WRITE.
- WRITE (1 cycle): wr_en=1 with the current wr_addr and wr_data.
  - Next cycle: if wr_addr==IMEM_DEPTH-1, set full<=1, hold wr_addr (no wrap-around) and go to FULLST.
  - Otherwise wr_addr<=wr_addr+1 and go to IDLE.
- FULLST: in_ready=0. Only load_addr is accepted; it performs the reload actions and goes to IDLE.
- load_addr is ignored in CHECK and WRITE.
- Latency: a request accepted in cycle N produces wr_en in cycle N+2. Sustained throughput is one word per 3 cycles.
- wr_en is high for exactly one cycle per legal request. wr_data is undefined-safe (holds its last value) when wr_en=0.

Optional Feature:
- Macro: INSTR_ENC_COUNT_EN.
- Defined: enc_count increments by 1 on every wr_en cycle, saturates at 16'hFFFF, and is cleared by reset and by load_addr.
- Undefined: enc_count is tied to 0 and no counter logic is generated.

Test Plan:
- R-type op=100, rs=2, rt=1 after load_addr with start_addr=8 -> wr_en at accept+2, wr_addr=8, wr_data=9'b010010010; then wr_addr=9.
- I-type op=001, rs=3, imm=5, followed by lov (op=010) with rs=6 -> wr_data=9'b100111101 then 9'b101011000 at consecutive addresses.
- S-type sidx=7'd8 -> wr_data=9'b000010001. Confirm in_ready is low during CHECK and WRITE.
- R-type with rs=5 -> no wr_en, err=1, err_code=01. Then kind=11 -> err_code=10. Then load_addr -> err=0.
- start_addr=IMEM_DEPTH-1, one legal request -> write at 255, full=1, in_ready=0, and the next in_valid is ignored. Then load_addr with start_addr=0 -> full=0 and writes resume at address 0.
- Assert rst_n=0 during CHECK -> no write occurs and all outputs return to their reset values. With INSTR_ENC_COUNT_EN defined, 3 writes -> enc_count=3.
